// File: rtl/priority_code_decoder.sv
// rtl/priority_code_decoder.sv - position code to one-hot decoder with hold/gap timing
// Optional one-entry prefetch: define PRIORITY_CODE_DECODER_PREFETCH_EN.
module priority_code_decoder #(
    parameter int WIDTH       = 4,
    parameter int CODE_W      = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [WIDTH-1:0]  onehot_out,
    output logic              onehot_valid,
    output logic              code_error,
    output logic              busy
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  onehot_q;
    logic              ready_en;
    logic              accept;
    logic              phase_end;
    logic              start;
    logic [CODE_W-1:0] start_code;
    logic              start_in_range;

    function automatic logic [WIDTH-1:0] decode(input logic [CODE_W-1:0] c);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < WIDTH; i++) begin
            d[i] = (c == CODE_W'(i + 1));
        end
        return d;
    endfunction

    assign accept    = code_valid && code_ready;
    assign phase_end = (cnt == '0);

`ifdef PRIORITY_CODE_DECODER_PREFETCH_EN
    logic              pf_full;
    logic [CODE_W-1:0] pf_code;
    logic              to_idle;
    logic              take_in;

    // A code may start directly only when the FSM is (or is about to be) idle;
    // any other accept parks in the prefetch entry.
    assign to_idle    = phase_end && ((state == S_GAP) || ((state == S_DRIVE) && (GAP_CYCLES == 0)));
    assign code_ready = ready_en && !pf_full;
    assign take_in    = accept && ((state == S_IDLE) || to_idle);
    assign start      = (pf_full && ((state == S_IDLE) || to_idle)) || take_in;
    assign start_code = pf_full ? pf_code : code_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pf_full <= 1'b0;
            pf_code <= '0;
        end else if (pf_full && start) begin
            pf_full <= 1'b0;
        end else if (accept && !take_in) begin
            pf_full <= 1'b1;
            pf_code <= code_in;
        end
    end
`else
    assign code_ready = ready_en && (state == S_IDLE);
    assign start      = accept;
    assign start_code = code_in;
`endif

    assign start_in_range = (start_code <= CODE_W'(WIDTH));
    assign onehot_valid   = (state == S_DRIVE);
    assign onehot_out     = onehot_valid ? onehot_q : '0;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            onehot_q   <= '0;
            ready_en   <= 1'b0;
            code_error <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            code_error <= 1'b0;
            if (start) begin
                if (start_in_range) begin
                    state    <= S_DRIVE;
                    cnt      <= HOLD_LOAD;
                    onehot_q <= decode(start_code);
                end else begin
                    state      <= S_IDLE;
                    cnt        <= '0;
                    code_error <= 1'b1;
                end
            end else begin
                case (state)
                    S_DRIVE: begin
                        if (!phase_end) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= S_GAP;
                            cnt   <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (phase_end) begin
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
